// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Pipeline hazard control for a classic 5-stage pipeline.
//   - Detects load-use hazards and stalls for LOAD_STALLS cycles.
//   - Flushes IF/ID and bubbles ID on a taken branch.
//   - Freezes the whole pipeline while data memory is busy.
//   - Keeps a saturating count of cycles in which the PC did not advance.
//
// Parameters
//   REG_W       register-address width
//   LOAD_STALLS bubble cycles per load-use hazard (1..7)
//   CNT_W       width of stall_cycles
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ID_EX_memRead, EX_rt     load in EX and its destination register
//   ID_rs, ID_rt             ID source registers
//   ID_use_rs, ID_use_rt     ID instruction actually reads rs / rt
//   branch_taken             branch resolved taken in EX
//   mem_busy                 data memory not ready (freeze everything)
//   PC_write .. EX_MEM_write pipeline write enables (1 = advance)
//   Mux_enable_ID            1 = zero ID control (bubble into EX)
//   IF_ID_flush              1 = clear IF/ID to NOP
//   stall_cycles             saturating count of cycles with PC_write = 0
//   state                    0 = RUN, 1 = LDSTALL
module hazard_control_unit #(
  parameter int REG_W       = 5,
  parameter int LOAD_STALLS = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_memRead,
  input  logic [REG_W-1:0] EX_rt,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             Mux_enable_ID,
  output logic             IF_ID_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             state
);

  typedef enum logic {RUN = 1'b0, LDSTALL = 1'b1} st_t;

  // The first stall cycle happens in RUN, so LDSTALL covers the rest.
  localparam logic [2:0] RELOAD = 3'(LOAD_STALLS - 1);

  st_t        st_q, st_d;
  logic [2:0] cnt_q, cnt_d;
  logic       hz;

  // Register 0 is hard-wired zero and can never carry a load-use hazard.
  assign hz = ID_EX_memRead && (EX_rt != '0) &&
              ((ID_use_rs && (EX_rt == ID_rs)) ||
               (ID_use_rt && (EX_rt == ID_rt)));

  always_comb begin
    PC_write      = 1'b1;
    IF_ID_write   = 1'b1;
    ID_EX_write   = 1'b1;
    EX_MEM_write  = 1'b1;
    Mux_enable_ID = 1'b0;
    IF_ID_flush   = 1'b0;
    st_d          = st_q;
    cnt_d         = cnt_q;
    if (rst) begin
      // outputs stay at their normal values; registers reset below
    end else if (mem_busy) begin
      // full freeze: state and down-counter hold
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
    end else if (branch_taken) begin
      // wrong-path instructions in IF and ID are discarded; any pending
      // load stall is moot because the ID instruction is being killed
      IF_ID_flush   = 1'b1;
      Mux_enable_ID = 1'b1;
      st_d          = RUN;
      cnt_d         = '0;
    end else if (st_q == LDSTALL || hz) begin
      PC_write      = 1'b0;
      IF_ID_write   = 1'b0;
      Mux_enable_ID = 1'b1;
      if (st_q == LDSTALL) begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) st_d = RUN;
      end else if (LOAD_STALLS > 1) begin
        st_d  = LDSTALL;
        cnt_d = RELOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= RUN;
      cnt_q        <= '0;
      stall_cycles <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      if (!PC_write && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  assign state = (st_q == LDSTALL);

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit
//   Drives three instances (LOAD_STALLS=1/CNT_W=16, LOAD_STALLS=3/CNT_W=16,
//   LOAD_STALLS=3/CNT_W=4) from one shared directed stimulus. A model built
//   on "remaining stall cycles" and a plain stall count predicts every
//   output each cycle; literal checks pin the model at key points.
module tb_hazard_control_unit;

  localparam int NI = 3;
  localparam int LSP [NI] = '{1, 3, 3};
  localparam int CWP [NI] = '{16, 16, 4};

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mr, use_rs, use_rt, br, mb;
  logic [4:0] ert, rs, rt;

  // {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, Mux_enable_ID, IF_ID_flush}
  wire [5:0]  en [NI];
  wire        stt [NI];
  wire [15:0] sc [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic pc, ii, ie, em, mx, fl, sv;
    logic [CWP[g]-1:0] s;
    hazard_control_unit #(.REG_W(5), .LOAD_STALLS(LSP[g]), .CNT_W(CWP[g])) u (
      .clk(clk), .rst(rst), .ID_EX_memRead(mr), .EX_rt(ert),
      .ID_rs(rs), .ID_rt(rt), .ID_use_rs(use_rs), .ID_use_rt(use_rt),
      .branch_taken(br), .mem_busy(mb),
      .PC_write(pc), .IF_ID_write(ii), .ID_EX_write(ie), .EX_MEM_write(em),
      .Mux_enable_ID(mx), .IF_ID_flush(fl), .stall_cycles(s), .state(sv));
    assign en[g]  = {pc, ii, ie, em, mx, fl};
    assign stt[g] = sv;
    assign sc[g]  = 16'(s);
  end

  int tests = 0, fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d @%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int rem [NI];   // stall cycles still owed after the current one
  int cnt [NI];   // cycles with PC frozen, saturating

  function automatic bit hzf();
    return mr && (ert != 0) && ((use_rs && ert == rs) || (use_rt && ert == rt));
  endfunction

  function automatic logic [5:0] exp_en(input int i);
    if (rst)                    return 6'b111100;
    if (mb)                     return 6'b000000;
    if (br)                     return 6'b111111;
    if (rem[i] > 0 || hzf())    return 6'b001110;
    return 6'b111100;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [5:0] e;
      e = exp_en(i);
      if (rst) begin
        rem[i] = 0;
        cnt[i] = 0;
      end else begin
        if (!e[5] && cnt[i] < (1 << CWP[i]) - 1) cnt[i] = cnt[i] + 1;
        if (!mb) begin
          if (br)              rem[i] = 0;
          else if (rem[i] > 0) rem[i] = rem[i] - 1;
          else if (hzf())      rem[i] = LSP[i] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("en%0d", i), int'(en[i]), int'(exp_en(i)));
        chk($sformatf("state%0d", i), int'(stt[i]), int'(rem[i] > 0));
        chk($sformatf("sc%0d", i), int'(sc[i]), cnt[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Applies one cycle of inputs just after the edge; returns with outputs settled.
  task automatic cyc(input bit r, input bit m, input int e, input int s, input int t,
                     input bit ur, input bit ut, input bit b, input bit busy);
    @(posedge clk); #1;
    rst = r; mr = m; ert = 5'(e); rs = 5'(s); rt = 5'(t);
    use_rs = ur; use_rt = ut; br = b; mb = busy;
    #1;
  endtask

  task automatic idle(); cyc(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic haz();  cyc(0, 1, 8, 8, 0, 1, 0, 0, 0); endtask
  task automatic rstc(); cyc(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  // {mr, ert, rs, rt, use_rs, use_rt, br, mb}
  typedef struct { bit m; int e; int s; int t; bit ur; bit ut; bit b; bit busy; } vec_t;
  vec_t tbl [16] = '{
    '{1, 5, 5, 1, 1, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
    '{1, 7, 2, 7, 0, 1, 0, 0}, '{1, 7, 7, 7, 1, 1, 0, 1},
    '{0, 0, 0, 0, 0, 0, 0, 0}, '{1, 3, 3, 3, 1, 1, 1, 0},
    '{1, 4, 4, 0, 1, 0, 0, 0}, '{1, 4, 4, 0, 1, 0, 0, 0},
    '{1, 4, 4, 0, 1, 0, 0, 0}, '{1, 4, 4, 0, 1, 0, 0, 0},
    '{0, 0, 0, 0, 0, 0, 1, 1}, '{0, 0, 0, 0, 0, 0, 1, 0},
    '{1, 0, 0, 0, 1, 1, 0, 0}, '{1, 31, 31, 1, 0, 0, 0, 0},
    '{1, 31, 1, 31, 0, 1, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}};

  initial begin
    rst = 1; mr = 0; ert = 0; rs = 0; rt = 0; use_rs = 0; use_rt = 0; br = 0; mb = 0;
    rstc();
    chk_en = 1'b1;
    rstc();
    chk("rst_pcw", int'(en[0][5]), 1);
    chk("rst_state1", int'(stt[1]), 0);
    chk("rst_sc1", int'(sc[1]), 0);

    // single-cycle hazard: 1 stall for LOAD_STALLS=1, 3 stalls for 3
    haz();
    chk("hz_pcw0", int'(en[0][5]), 0);
    chk("hz_ifid0", int'(en[0][4]), 0);
    chk("hz_mux0", int'(en[0][1]), 1);
    idle();
    chk("after_pcw0", int'(en[0][5]), 1);
    chk("after_mux0", int'(en[0][1]), 0);
    chk("ld_state1_a", int'(stt[1]), 1);
    chk("ld_pcw1_a", int'(en[1][5]), 0);
    idle();
    chk("ld_state1_b", int'(stt[1]), 1);
    chk("sc0_one", int'(sc[0]), 1);
    idle();
    chk("ld_state1_c", int'(stt[1]), 0);
    chk("ld_pcw1_c", int'(en[1][5]), 1);
    chk("sc1_three", int'(sc[1]), 3);

    // register 0 and unused operands never stall
    cyc(0, 1, 0, 0, 0, 1, 0, 0, 0);
    chk("r0_pcw0", int'(en[0][5]), 1);
    cyc(0, 1, 9, 3, 9, 1, 0, 0, 0);
    chk("nouse_pcw0", int'(en[0][5]), 1);
    cyc(0, 1, 9, 3, 9, 0, 1, 0, 0);
    chk("rt_hz_pcw0", int'(en[0][5]), 0);
    idle(); idle(); idle();

    // mem_busy in the middle of LDSTALL
    rstc();
    haz();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("busy_en1", int'(en[1]), 0);
    chk("busy_state1", int'(stt[1]), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("busy_en1_b", int'(en[1]), 0);
    idle();
    chk("resume_state1", int'(stt[1]), 1);
    chk("resume_pcw1", int'(en[1][5]), 0);
    idle(); idle();
    chk("busy_sc1", int'(sc[1]), 5);
    chk("busy_state1_end", int'(stt[1]), 0);

    // branch wins over a hazard, and abandons a pending stall
    cyc(0, 1, 8, 8, 0, 1, 0, 1, 0);
    chk("br_flush", int'(en[1][0]), 1);
    chk("br_mux", int'(en[1][1]), 1);
    chk("br_pcw", int'(en[1][5]), 1);
    idle();
    chk("br_state1", int'(stt[1]), 0);
    haz();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("br_ld_flush1", int'(en[1][0]), 1);
    idle();
    chk("br_ld_state1", int'(stt[1]), 0);
    chk("br_ld_pcw1", int'(en[1][5]), 1);

    // reset aborts LDSTALL
    haz();
    rstc();
    chk("rst_mid_pcw1", int'(en[1][5]), 1);
    idle();
    chk("rst_mid_state1", int'(stt[1]), 0);

    // saturation with CNT_W=4
    rstc();
    for (int k = 0; k < 20; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("sat_sc2", int'(sc[2]), 15);
    chk("sat_sc1", int'(sc[1]), 20);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_over_busy", int'(en[2][5]), 1);
    idle();
    chk("sat_rst_sc2", int'(sc[2]), 0);
    chk("sat_rst_state2", int'(stt[2]), 0);

    // mixed directed table, checked by the per-cycle model
    foreach (tbl[k])
      cyc(0, tbl[k].m, tbl[k].e, tbl[k].s, tbl[k].t, tbl[k].ur, tbl[k].ut, tbl[k].b, tbl[k].busy);
    idle(); idle(); idle();

    @(posedge clk); #2;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter REG_W, default 5: register-address width.
REQ-002 Parameter LOAD_STALLS, default 1, legal range 1..7: bubble cycles inserted per load-use hazard.
REQ-003 Parameter CNT_W, default 16: width of the stall statistics counter.
REQ-004 One clock; reset is synchronous and active-high; ports are clk and rst.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 ID_EX_memRead  input  1  instruction in EX is a load.
REQ-008 EX_rt  input  REG_W  load destination register in EX.
REQ-009 ID_rs, ID_rt  input  REG_W each  source registers of instruction in ID.
REQ-010 ID_use_rs, ID_use_rt  input  1 each  ID instruction actually reads rs / rt.
REQ-011 branch_taken  input  1  branch resolved taken in EX.
REQ-012 mem_busy  input  1  data memory not ready; whole pipeline must freeze.
REQ-013 PC_write  output  1  PC update enable (1 = advance).
REQ-014 IF_ID_write  output  1  IF/ID register load enable (1 = load).
REQ-015 ID_EX_write, EX_MEM_write  output  1 each  pipeline register load enables.
REQ-016 Mux_enable_ID  output  1  1 = zero ID control signals (insert bubble into EX).
REQ-017 IF_ID_flush  output  1  1 = clear IF/ID to NOP.
REQ-018 stall_cycles  output  CNT_W  saturating count of stalled cycles.
REQ-019 state  output  1  0 = RUN, 1 = LDSTALL.

Function
REQ-020 hz = ID_EX_memRead & (EX_rt != 0) & ((ID_use_rs & EX_rt == ID_rs) | (ID_use_rt & EX_rt == ID_rt)); register 0 never causes a hazard.
REQ-021 Priority per cycle: rst > mem_busy > branch_taken > load stall (hz in RUN, or LDSTALL state) > normal.
REQ-022 Normal: all write enables 1, Mux_enable_ID 0, IF_ID_flush 0.
REQ-023 mem_busy=1 (any state): PC_write, IF_ID_write, ID_EX_write, EX_MEM_write all 0; Mux_enable_ID 0; IF_ID_flush 0; state and internal down-counter hold; branch_taken and hz ignored that cycle.
REQ-024 branch_taken=1 with mem_busy=0: IF_ID_flush 1, Mux_enable_ID 1, all write enables 1; next state RUN; any pending load stall abandoned, down-counter cleared.
REQ-025 Load stall cycle: PC_write 0, IF_ID_write 0, Mux_enable_ID 1, ID_EX_write 1, EX_MEM_write 1, IF_ID_flush 0.
REQ-026 RUN with hz=1: load stall cycle; if LOAD_STALLS=1 stay RUN; else go LDSTALL with down-counter = LOAD_STALLS-1.
REQ-027 LDSTALL: load stall cycle regardless of hz; down-counter decrements; when down-counter = 1 next state RUN.
REQ-028 Total consecutive stall cycles per hazard (mem_busy=0, no branch) = exactly LOAD_STALLS.
REQ-029 On return to RUN, hz re-evaluated normally; a new hazard starts a new stall sequence immediately.
REQ-030 stall_cycles increments by 1 each non-reset cycle in which PC_write=0 (load stall or mem_busy); saturates at 2^CNT_W-1, no wrap.
REQ-031 All outputs except stall_cycles and state are combinational from state, down-counter and inputs; no extra latency.

Reset
REQ-032 rst=1 at a clock edge: state RUN, down-counter 0, stall_cycles 0, effective next cycle.
REQ-033 While rst=1: all write enables 1, Mux_enable_ID 0, IF_ID_flush 0; stall_cycles does not increment.
REQ-034 rst asserted mid-LDSTALL aborts the stall; first cycle after reset is RUN.

Verification
REQ-035 LOAD_STALLS=1: memRead=1, EX_rt=8, ID_rs=8, use_rs=1 for one cycle -> PC_write=0, IF_ID_write=0, Mux_enable_ID=1 that cycle only; stall_cycles 0->1.
REQ-036 EX_rt=0, ID_rs=0, memRead=1 -> no stall; also EX_rt=9=ID_rt with use_rt=0 -> no stall.
REQ-037 LOAD_STALLS=3: hazard one cycle then memRead=0 -> exactly 3 stall cycles, state 0,1,1,0; stall_cycles=3.
REQ-038 LOAD_STALLS=3: mem_busy=1 for 2 cycles during LDSTALL -> all enables 0 for those 2 cycles, state held, stall still totals 3 load-stall cycles afterwards; stall_cycles=5.
REQ-039 branch_taken=1 together with hz=1 -> IF_ID_flush=1, Mux_enable_ID=1, PC_write=1, state stays RUN.
REQ-040 CNT_W=4, mem_busy held 20 cycles -> stall_cycles saturates at 15; rst=1 -> stall_cycles 0, state 0 next cycle.
